// File: rtl/step_motor_pkg.sv
// Shared definitions for the stepper coil bus: phase codes, decoder states
// and the default position width.
package step_motor_pkg;

    localparam int POS_W_DEFAULT = 12;

    localparam logic [3:0] PH0    = 4'b1100;
    localparam logic [3:0] PH1    = 4'b0110;
    localparam logic [3:0] PH2    = 4'b0011;
    localparam logic [3:0] PH3    = 4'b1001;
    localparam logic [3:0] PH_OFF = 4'b0000;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        FAULT    = 2'd2
    } state_t;

endpackage

// File: rtl/step_phase_lut.sv
// Combinational coil pattern classifier: valid phase index, coils-off, or
// neither (illegal pattern).
module step_phase_lut
    import step_motor_pkg::*;
(
    input  logic [3:0] i_signal,
    output logic       o_valid,
    output logic       o_off,
    output logic [1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_off   = 1'b0;
        o_idx   = 2'd0;
        case (i_signal)
            PH0:     begin o_valid = 1'b1; o_idx = 2'd0; end
            PH1:     begin o_valid = 1'b1; o_idx = 2'd1; end
            PH2:     begin o_valid = 1'b1; o_idx = 2'd2; end
            PH3:     begin o_valid = 1'b1; o_idx = 2'd3; end
            PH_OFF:  o_off = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/step_phase_decoder.sv
// Receive-side stepper coil monitor: decodes phase steps into a signed
// position, direction and motion flag, and latches illegal/skipped phases.
// Define STEP_DEC_SYNC_EN to add a 2-flop input synchronizer for pin-sourced coils.
module step_phase_decoder
    import step_motor_pkg::*;
#(
    parameter int POS_W    = POS_W_DEFAULT,
    parameter int IDLE_CYC = 4
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic [3:0]       signal,
    input  logic             clear,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_pulse,
    output logic             moving,
    output logic             err
);

    localparam int                IDLE_W   = $clog2(IDLE_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYC);

    logic [3:0]        w_sample;
    logic              w_valid;
    logic              w_off;
    logic [1:0]        w_idx;
    logic [1:0]        w_delta;
    logic [IDLE_W-1:0] w_idle_inc;

    state_t            r_state;
    logic [1:0]        r_last;
    logic [IDLE_W-1:0] r_idle;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic              r_pulse;
    logic              r_moving;
    logic              r_err;

`ifdef STEP_DEC_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= signal;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = signal;
`endif

    step_phase_lut u_lut (
        .i_signal (w_sample),
        .o_valid  (w_valid),
        .o_off    (w_off),
        .o_idx    (w_idx)
    );

    // Two-bit subtraction wraps naturally, giving the phase delta mod 4.
    assign w_delta    = w_idx - r_last;
    assign w_idle_inc = (r_idle == IDLE_MAX) ? IDLE_MAX : r_idle + 1'b1;

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            r_state  <= UNLOCKED;
            r_last   <= 2'd0;
            r_idle   <= '0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_pulse  <= 1'b0;
            r_moving <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (clear) begin
                r_state  <= UNLOCKED;
                r_idle   <= '0;
                r_pos    <= '0;
                r_moving <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    UNLOCKED: begin
                        if (w_valid) begin
                            r_last  <= w_idx;
                            r_state <= TRACK;
                        end else if (!w_off) begin
                            r_state <= FAULT;
                            r_err   <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (w_off) begin
                            r_moving <= 1'b0;
                            r_idle   <= IDLE_MAX;
                        end else if (!w_valid) begin
                            r_state  <= FAULT;
                            r_err    <= 1'b1;
                            r_moving <= 1'b0;
                        end else begin
                            case (w_delta)
                                2'd0: begin
                                    r_idle <= w_idle_inc;
                                    if (w_idle_inc == IDLE_MAX) r_moving <= 1'b0;
                                end
                                2'd1: begin
                                    r_pos    <= r_pos + 1'b1;
                                    r_dir    <= 1'b1;
                                    r_pulse  <= 1'b1;
                                    r_moving <= 1'b1;
                                    r_idle   <= '0;
                                    r_last   <= w_idx;
                                end
                                2'd3: begin
                                    r_pos    <= r_pos - 1'b1;
                                    r_dir    <= 1'b0;
                                    r_pulse  <= 1'b1;
                                    r_moving <= 1'b1;
                                    r_idle   <= '0;
                                    r_last   <= w_idx;
                                end
                                default: begin
                                    r_state  <= FAULT;
                                    r_err    <= 1'b1;
                                    r_moving <= 1'b0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_moving <= 1'b0;
                        r_err    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign position   = r_pos;
    assign dir        = r_dir;
    assign step_pulse = r_pulse;
    assign moving     = r_moving;
    assign err        = r_err;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Self-checking bench for step_phase_decoder (default build, 1-cycle latency):
// directed scenarios plus randomized coil traffic against a behavioural model.
module tb_step_phase_decoder;

    localparam int POS_W    = 12;
    localparam int IDLE_CYC = 4;
    localparam int POS_MOD  = 1 << POS_W;

    logic             divClk;
    logic             rst;
    logic [3:0]       signalIn;
    logic             clearIn;
    logic [POS_W-1:0] position;
    logic             dir;
    logic             stepPulse;
    logic             moving;
    logic             err;

    int nChecks = 0;
    int nFails  = 0;
    bit chkEn   = 0;

    // Model state: 0 = unlocked, 1 = tracking, 2 = faulted.
    int mState, mLast, mIdle, mPos;
    bit mDir, mPulse, mMoving, mErr;

    logic [3:0] codes [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

    step_phase_decoder #(.POS_W(POS_W), .IDLE_CYC(IDLE_CYC)) dut (
        .div_clk    (divClk),
        .rst        (rst),
        .signal     (signalIn),
        .clear      (clearIn),
        .position   (position),
        .dir        (dir),
        .step_pulse (stepPulse),
        .moving     (moving),
        .err        (err)
    );

    initial begin
        divClk = 1'b0;
        forever #5 divClk = ~divClk;
    end

    // Phase index 0..3, 4 for coils off, 5 for illegal.
    function automatic int phaseOf(logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s == codes[i]) return i;
        if (s == 4'b0000) return 4;
        return 5;
    endfunction

    always @(posedge divClk or posedge rst) begin
        if (rst) begin
            mState = 0; mLast = 0; mIdle = 0; mPos = 0;
            mDir = 0; mPulse = 0; mMoving = 0; mErr = 0;
        end else begin
            int ph, d;
            ph = phaseOf(signalIn);
            mPulse = 0;
            if (clearIn) begin
                mState = 0; mPos = 0; mErr = 0; mMoving = 0; mIdle = 0;
            end else if (mState == 0) begin
                if (ph < 4) begin mLast = ph; mState = 1; end
                else if (ph == 5) begin mState = 2; mErr = 1; end
            end else if (mState == 1) begin
                if (ph == 4) begin
                    mMoving = 0; mIdle = IDLE_CYC;
                end else if (ph == 5) begin
                    mState = 2; mErr = 1; mMoving = 0;
                end else begin
                    d = (ph - mLast + 4) % 4;
                    if (d == 0) begin
                        mIdle = (mIdle + 1 > IDLE_CYC) ? IDLE_CYC : mIdle + 1;
                        if (mIdle == IDLE_CYC) mMoving = 0;
                    end else if (d == 2) begin
                        mState = 2; mErr = 1; mMoving = 0;
                    end else begin
                        mPos    = (d == 1) ? (mPos + 1) % POS_MOD : (mPos + POS_MOD - 1) % POS_MOD;
                        mDir    = (d == 1);
                        mPulse  = 1; mMoving = 1; mIdle = 0; mLast = ph;
                    end
                end
            end else begin
                mMoving = 0; mErr = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset, all outputs must match the model.
    always @(negedge divClk) begin
        if (chkEn && !rst) begin
            checkOutput("position", 32'(position), 32'(mPos));
            checkOutput("dir", 32'(dir), 32'(mDir));
            checkOutput("step_pulse", 32'(stepPulse), 32'(mPulse));
            checkOutput("moving", 32'(moving), 32'(mMoving));
            checkOutput("err", 32'(err), 32'(mErr));
        end
    end

    task automatic applyStimulus(input logic [3:0] s, input logic c);
        signalIn = s;
        clearIn  = c;
        @(negedge divClk);
    endtask

    int pulseCount;

    initial begin
        rst = 1'b1; signalIn = 4'b0000; clearIn = 1'b0;
        repeat (2) @(negedge divClk);
        checkOutput("reset_position", 32'(position), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        chkEn = 1'b1;

        // Forward run: first sample locks, then four steps.
        pulseCount = 0;
        foreach (codes[i]) begin
            applyStimulus(codes[i], 1'b0);
            pulseCount += stepPulse;
        end
        applyStimulus(4'b1100, 1'b0);
        pulseCount += stepPulse;
        checkOutput("fwd_position", 32'(position), 32'd4);
        checkOutput("fwd_model_pos", 32'(mPos), 32'd4);
        checkOutput("fwd_dir", 32'(dir), 32'd1);
        checkOutput("fwd_pulses", 32'(pulseCount), 32'd4);
        checkOutput("fwd_moving", 32'(moving), 32'd1);

        // Reverse: hold, then two backward steps.
        applyStimulus(4'b1100, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        applyStimulus(4'b0011, 1'b0);
        checkOutput("rev_position", 32'(position), 32'd2);
        checkOutput("rev_dir", 32'(dir), 32'd0);

        // Idle timeout, then coils off.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0011, 1'b0);
            if (i == 2) checkOutput("idle_still_moving", 32'(moving), 32'd1);
        end
        checkOutput("idle_moving", 32'(moving), 32'd0);
        checkOutput("idle_position", 32'(position), 32'd2);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("off_err", 32'(err), 32'd0);

        // Skipped phase freezes position until clear.
        applyStimulus(4'b1001, 1'b0);
        applyStimulus(4'b1100, 1'b0);
        applyStimulus(4'b0011, 1'b0);
        checkOutput("skip_err", 32'(err), 32'd1);
        checkOutput("skip_position", 32'(position), 32'd4);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("frozen_position", 32'(position), 32'd4);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("clear_position", 32'(position), 32'd0);
        checkOutput("clear_err", 32'(err), 32'd0);

        // Illegal pattern while unlocked, then asynchronous reset.
        applyStimulus(4'b1111, 1'b0);
        checkOutput("illegal_err", 32'(err), 32'd1);
        signalIn = 4'b0000;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_err", 32'(err), 32'd0);
        checkOutput("async_rst_moving", 32'(moving), 32'd0);
        #1 rst = 1'b0;
        @(negedge divClk);

        // Reverse wrap below zero, then clear racing a forward step.
        applyStimulus(4'b1100, 1'b0);
        checkOutput("lock_position", 32'(position), 32'd0);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("wrap_position", 32'(position), 32'd4095);
        checkOutput("wrap_dir", 32'(dir), 32'd0);
        checkOutput("wrap_err", 32'(err), 32'd0);
        applyStimulus(4'b1100, 1'b1);
        checkOutput("clear_step_pulse", 32'(stepPulse), 32'd0);
        checkOutput("clear_step_position", 32'(position), 32'd0);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("relock_position", 32'(position), 32'd0);

        // Randomized traffic around a tracked phase.
        begin
            int cur, r;
            logic [3:0] pat;
            cur = 1;
            for (int n = 0; n < 3000; n++) begin
                r = $urandom_range(0, 99);
                if (r < 4 || (mErr && r < 25)) begin
                    cur = $urandom_range(0, 3);
                    applyStimulus(codes[cur], 1'b1);
                end else if (r < 10) begin
                    applyStimulus(4'b0000, 1'b0);
                end else if (r < 13) begin
                    pat = 4'($urandom);
                    while (phaseOf(pat) != 5) pat = pat + 4'd3;
                    applyStimulus(pat, 1'b0);
                end else if (r < 16) begin
                    cur = (cur + 2) % 4;
                    applyStimulus(codes[cur], 1'b0);
                end else if (r < 40) begin
                    applyStimulus(codes[cur], 1'b0);
                end else if (r < 72) begin
                    cur = (cur + 1) % 4;
                    applyStimulus(codes[cur], 1'b0);
                end else begin
                    cur = (cur + 3) % 4;
                    applyStimulus(codes[cur], 1'b0);
                end
            end
        end

        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
